// File: rtl/div_seq_if.sv
// Issue/result bundle between execute and the divide sequencer.
// master: start/op/operands/flush out; stall/done/result in.
interface div_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output stall, done, result
    );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one bit per cycle.
// Ports: clk, rstn (async, active low), bus (div_seq_if.slave).
module div_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rstn,
    div_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            isrem_q, isrem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sgn_in;
    logic            rem_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign sgn_in   = ~bus.op[0];
    assign rem_in   = bus.op[1];
    assign a_neg    = sgn_in & bus.dividend[XLEN-1];
    assign b_neg    = sgn_in & bus.divisor[XLEN-1];
    assign a_mag    = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag    = b_neg ? -bus.divisor : bus.divisor;
    assign div_zero = (bus.divisor == '0);
    assign ovf      = sgn_in & (bus.dividend == MIN_NEG)
                    & (bus.divisor == '1);

    // Shifted partial remainder is XLEN+1 bits wide; a clear top bit
    // of the difference means the divisor fits.
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    // Sign flags are only ever set for signed ops.
    assign q_fix = qneg_q ? -quo_q : quo_q;
    assign r_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        isrem_d  = isrem_q;
        result_d = result_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (div_zero) begin
                            result_d = rem_in ? bus.dividend : '1;
                            state_d  = DONE;
                        end else if (ovf) begin
                            result_d = rem_in ? '0 : MIN_NEG;
                            state_d  = DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            isrem_d = rem_in;
                            cnt_d   = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[XLEN]) begin
                        rem_d = trial[XLEN-1:0];
                    end else begin
                        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    end
                    quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = FIXUP;
                    end
                end
                FIXUP: begin
                    result_d = isrem_q ? r_fix : q_fix;
                    state_d  = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            isrem_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            isrem_q  <= isrem_d;
            result_q <= result_d;
        end
    end

    // Stall drops in DONE so the instruction retires with its result.
    assign bus.stall = ~bus.flush & (
                         ((state_q == IDLE) & bus.start)
                       | (state_q == CALC)
                       | (state_q == FIXUP));
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: random and directed RV32M divides
// checked against a plain-arithmetic reference model.
module tb_div_seq;

    logic clk;
    logic rstn;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_res;

    div_seq_if #(.XLEN(32)) bus ();

    div_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_div(
        input logic [1:0] o, input logic [31:0] a, input logic [31:0] b
    );
        longint sa;
        longint sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(
        input logic [1:0] o, input logic [31:0] a, input logic [31:0] b
    );
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: done at cycle %0d, none expected",
                         cyc);
            end else begin
                e = sb_q.pop_front();
                chk("result", bus.result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Caller is just after a rising edge; this cycle becomes cycle 0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        exp_t e;
        bus.start    = 1'b1;
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        lat   = ref_lat(o, a, b);
        e.res = ref_div(o, a, b);
        e.due = cyc + lat;
        sb_q.push_back(e);
        last_res = e.res;
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
        int lat;
        int bad;
        issue(o, a, b, lat);
        bad = 0;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (bus.stall !== (c < lat)) bad++;
            @(posedge clk);
            #1;
            if (c == 0) bus.start = 1'b0;
            // A start during DONE must be ignored.
            if (poke && c == lat - 1) begin
                bus.start   = 1'b1;
                bus.op      = 2'($urandom_range(0, 3));
                bus.divisor = 32'd0;
            end
        end
        bus.start = 1'b0;
        chk("stall_profile_bad_cycles", 32'(bad), 32'd0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        checks   = 0;
        failures = 0;
        last_res = 32'd0;
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        run(2'b01, 32'd100, 32'd7, 1'b0);
        run(2'b11, 32'd100, 32'd7, 1'b0);
        run(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run(2'b01, 32'd5, 32'd0, 1'b0);
        run(2'b10, 32'h8000_0001, 32'd0, 1'b0);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("divu_ovf_operands", bus.result, 32'd0);

        // Flush mid-CALC, with an ignored second start in cycle 5.
        bus.start    = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.start   = 1'b1;
        bus.divisor = 32'd0;
        #1;
        chk("stall_calc", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        #1;
        chk("stall_flush", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("result_keep_flush", bus.result, last_res);
        run(2'b01, 32'd1000, 32'd3, 1'b0);
        chk("after_flush_333", bus.result, 32'd333);

        // flush with start in IDLE accepts nothing.
        bus.start   = 1'b1;
        bus.flush   = 1'b1;
        bus.divisor = 32'd0;
        #1;
        chk("stall_flush_start", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("stall_after_flush_start", 32'(bus.stall), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("result_keep_flush_start", bus.result, last_res);

        // Randomized operations.
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 9));
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) a = 32'($urandom_range(0, 100));
            if (sel == 4) b = -32'($urandom_range(1, 15));
            run(2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 1) == 1));
        end

        // Reset mid-operation in cycle 20.
        issue(2'b00, 32'hFFFF_0000, 32'd3, lat);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        #1;
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        sb_q.delete();
        last_res = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run(2'b01, 32'd9, 32'd3, 1'b0);
        chk("after_reset_9_3", bus.result, 32'd3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for RV32M divide/remainder (DIV, DIVU, REM, REMU) beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time and runs a radix-2 restoring divide, one bit per cycle.
- Drives a stall that freezes the pipeline around execute until the result is ready.
- Handles the RISC-V divide-by-zero and signed-overflow cases on a fast path.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  input  1  core clock.
- rstn  input  1  asynchronous reset, active low.
- start  input  1  issue request; sampled only in IDLE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- flush  input  1  abort the current operation (branch/jump taken).
- stall  output  1  holds the pipeline in front of execute.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, done 0, result 0, counter 0, internal regs 0. Reset at any time, including mid-CALC, aborts the operation and produces no done.
- Signedness: signed = ~op[0]. Signed ops register |dividend|, |divisor|, quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)).
- Cycle numbering: cycle 0 is the cycle in which start is sampled high.
- IDLE:
  - start & ~flush & divisor==0 -> DONE (fast). Result = all ones for quotient ops, dividend for remainder ops.
  - start & ~flush & signed & dividend==0x80000000 & divisor==0xFFFFFFFF -> DONE (fast). Result = 0x80000000 for DIV, 0 for REM.
  - Any other start & ~flush -> CALC. Load magnitudes, clear partial remainder, counter = 0.
- CALC:
  - Each cycle: shift {rem, quo} left 1; trial = rem - divisor_mag (XLEN+1 bits).
  - If trial is non-negative: rem = trial, quo LSB = 1; otherwise quo LSB = 0.
  - counter increments each cycle; after the XLEN-th iteration (counter == XLEN-1) -> FIXUP.
- FIXUP (1 cycle): negate quo if the quotient sign is set and the op is signed; negate rem if the remainder sign is set and the op is signed. Register the selected value into result. Next state DONE.
- DONE (1 cycle): done = 1, result valid. Next state IDLE.
- Latency: normal path done in cycle XLEN+2 (34); fast path done in cycle 1.
- stall = (IDLE & start & ~flush) | CALC | FIXUP. It is combinational from start in cycle 0 and low in the DONE cycle so the instruction retires with its result.
- Fast-path stall: high in cycle 0 only.
- start outside IDLE is ignored; no queueing.
- start in the DONE cycle is also ignored. The next request may be issued in the following cycle (IDLE).
- flush in any state:
  - next state IDLE, no done, stall low combinationally in that cycle;
  - result keeps its previous value;
  - flush together with start in IDLE means nothing is accepted.
- result holds its last value until the next FIXUP or fast-path completion overwrites it.

Test Plan:
- Basic unsigned: DIVU 100/7 -> stall high cycles 0-33, done pulses in cycle 34 only, result 14; repeat with REMU -> result 2.
- Signed: DIV 0xFFFFFFF9(-7)/2 -> result 0xFFFFFFFD(-3); REM -7/2 -> 0xFFFFFFFF(-1); REM 7/-2 -> 1.
- Divide by zero: DIVU 5/0 -> done in cycle 1, result 0xFFFFFFFF; REM 0x80000001/0 -> 0x80000001; stall high in cycle 0 only.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> fast done, result 0x80000000; REM -> 0; same operands with DIVU -> normal 34-cycle path, result 0.
- Flush and ignore: start DIVU 1000/3, flush in cycle 10 -> stall low in cycle 10, no done pulse afterwards, result unchanged. Second start during CALC is ignored. A start in cycle 11 completes with 333 in its cycle 34.
- Reset mid-operation: rstn low in cycle 20 of a DIV -> done 0 and result 0 immediately. After release, a new DIVU 9/3 gives result 3.
